// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces three coin sensors, then buffers the coin codes in a FIFO.
// Codes are emitted one at a time to the vending FSM, with all-zero gap cycles between them.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int MIN_GAP         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_q,
    input  logic       coin_h,
    input  logic       coin_d,
    input  logic       accept_en,
    output logic [2:0] money,
    output logic       coin_reject,
    output logic [2:0] fifo_count,
    output logic [7:0] credit_total
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]       DB_MAX   = 4'(DEBOUNCE_CYCLES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [7:0]       GAP_LAST = 8'(MIN_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [2:0]       raw_s;
    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0][3:0]  db_cnt_r;
    logic [2:0]       held_r;
    logic [2:0]       event_s;
    logic             jam_s;
    logic             single_s;
    logic [1:0]       code_s;
    logic [2:0]       value_s;

    logic [1:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [2:0]       count_r;
    logic             full_s;
    logic             nonempty_s;
    logic             enq_s;
    logic             deq_s;
    logic             reject_s;
    logic [8:0]       credit_sum_s;

    state_t           state_r;
    state_t           next_state_s;
    logic [7:0]       gap_cnt_r;
    logic             gap_last_s;
    logic [2:0]       money_next_s;

    logic [2:0]       money_r;
    logic             coin_reject_r;
    logic [7:0]       credit_r;

    // Bit 0 = quarter, bit 1 = half, bit 2 = dollar throughout.
    assign raw_s = {coin_d, coin_h, coin_q};

    // Two-flop synchronizers for the asynchronous sensor levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Saturating debounce counters; held_r blocks repeat events until the level drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_r <= '0;
            held_r   <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i]) begin
                    if (db_cnt_r[i] != DB_MAX) begin
                        db_cnt_r[i] <= db_cnt_r[i] + 4'd1;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i];
                    end
                    if (event_s[i]) begin
                        held_r[i] <= 1'b1;
                    end else begin
                        held_r[i] <= held_r[i];
                    end
                end else begin
                    db_cnt_r[i] <= 4'd0;
                    held_r[i]   <= 1'b0;
                end
            end
        end
    end

    // Event decode: one-hot events become a code and value; anything wider is a jam.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            event_s[i] = (db_cnt_r[i] == DB_MAX) && !held_r[i];
        end
        jam_s    = (event_s[0] & event_s[1]) | (event_s[0] & event_s[2]) | (event_s[1] & event_s[2]);
        single_s = (|event_s) & ~jam_s;
        case (event_s)
            3'b001: begin
                code_s  = 2'b01;
                value_s = 3'd1;
            end
            3'b010: begin
                code_s  = 2'b10;
                value_s = 3'd2;
            end
            3'b100: begin
                code_s  = 2'b11;
                value_s = 3'd4;
            end
            default: begin
                code_s  = 2'b00;
                value_s = 3'd0;
            end
        endcase
    end

    assign full_s     = (count_r == 3'(FIFO_DEPTH));
    assign nonempty_s = (count_r != 3'd0);
    assign gap_last_s = (gap_cnt_r == GAP_LAST);

    // A full FIFO still accepts a coin when the head leaves on the same edge.
    always_comb begin
        deq_s        = (next_state_s == ST_EMIT);
        enq_s        = single_s && (!full_s || deq_s);
        reject_s     = jam_s || (single_s && !enq_s);
        credit_sum_s = {1'b0, credit_r} + {6'd0, value_s};
    end

    // FIFO storage, wrapping pointers, occupancy and credit accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 2'b00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 3'd0;
            credit_r <= 8'd0;
        end else begin
            if (enq_s) begin
                mem_r[wr_ptr_r] <= code_s;
                wr_ptr_r        <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + 1'b1;
                credit_r        <= credit_sum_s[8] ? 8'd255 : credit_sum_s[7:0];
            end
            if (deq_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + 1'b1;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Emitter state register and gap-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 8'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r != ST_GAP) begin
                gap_cnt_r <= 8'd0;
            end else if (!gap_last_s) begin
                gap_cnt_r <= gap_cnt_r + 8'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end

    // Emitter next state. The last gap cycle falls through the IDLE decision so
    // back-to-back codes are separated by exactly MIN_GAP zero cycles.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (nonempty_s && accept_en) begin
                    next_state_s = ST_EMIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                next_state_s = ST_GAP;
            end
            ST_GAP: begin
                if (!gap_last_s) begin
                    next_state_s = ST_GAP;
                end else if (nonempty_s && accept_en) begin
                    next_state_s = ST_EMIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Emitter output: the head code is presented only on the edge entering EMIT.
    always_comb begin
        if (deq_s) begin
            money_next_s = {1'b0, mem_r[rd_ptr_r]};
        end else begin
            money_next_s = 3'b000;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            money_r       <= 3'b000;
            coin_reject_r <= 1'b0;
        end else begin
            money_r       <= money_next_s;
            coin_reject_r <= reject_s;
        end
    end

    assign money        = money_r;
    assign coin_reject  = coin_reject_r;
    assign fifo_count   = count_r;
    assign credit_total = credit_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor with default parameters (debounce 4, depth 4, gap 1).
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] coins = 3'b000;
    logic       accept_en = 1'b0;
    logic [2:0] money;
    logic       coin_reject;
    logic [2:0] fifo_count;
    logic [7:0] credit_total;

    int n_total = 0;
    int n_pass  = 0;
    int rej_cnt = 0;
    logic [2:0] seen [$];

    coin_acceptor dut (
        .clk          (clk),
        .rst          (rst),
        .coin_q       (coins[0]),
        .coin_h       (coins[1]),
        .coin_d       (coins[2]),
        .accept_en    (accept_en),
        .money        (money),
        .coin_reject  (coin_reject),
        .fifo_count   (fifo_count),
        .credit_total (credit_total)
    );

    always #5 clk = ~clk;

    // One clock edge, then sample 1 time unit later and log reject pulses / emitted codes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (coin_reject) rej_cnt++;
        if (money != 3'b000) seen.push_back(money);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        coins = 3'b000;
        ticks(2);
        rst = 1'b0;
        rej_cnt = 0;
        seen.delete();
    endtask

    // Hold the given sensors high for 5 sampled edges, then low for 3.
    task automatic insert(input logic [2:0] which);
        coins = which;
        ticks(5);
        coins = 3'b000;
        ticks(3);
    endtask

    initial begin
        int w;

        // Reset state
        accept_en = 1'b1;
        coins = 3'b111;
        ticks(2);
        chk("rst_money", {5'd0, money}, 8'd0);
        chk("rst_reject", {7'd0, coin_reject}, 8'd0);
        chk("rst_count", {5'd0, fifo_count}, 8'd0);
        chk("rst_credit", credit_total, 8'd0);
        do_reset();

        // Single quarter: code appears exactly 8 edges after the first sample
        coins = 3'b001;
        ticks(7);
        chk("lat_before", {5'd0, money}, 8'd0);
        tick();
        chk("lat_emit", {5'd0, money}, 8'd1);
        chk("lat_credit", credit_total, 8'd1);
        tick();
        chk("lat_after", {5'd0, money}, 8'd0);
        tick();
        coins = 3'b000;
        ticks(10);
        chk("lat_once", 8'(seen.size()), 8'd1);
        chk("lat_norej", 8'(rej_cnt), 8'd0);

        // Short pulse: 3 cycles high never qualifies
        do_reset();
        coins = 3'b001;
        ticks(3);
        coins = 3'b000;
        ticks(12);
        chk("short_none", 8'(seen.size()), 8'd0);
        chk("short_credit", credit_total, 8'd0);

        // Jam: half and dollar qualify together
        do_reset();
        coins = 3'b110;
        ticks(10);
        coins = 3'b000;
        ticks(4);
        chk("jam_reject", 8'(rej_cnt), 8'd1);
        chk("jam_count", {5'd0, fifo_count}, 8'd0);
        chk("jam_credit", credit_total, 8'd0);
        chk("jam_none", 8'(seen.size()), 8'd0);

        // Overflow: five quarters into a depth-4 FIFO while stalled
        do_reset();
        accept_en = 1'b0;
        for (int i = 0; i < 5; i++) insert(3'b001);
        ticks(4);
        chk("ovf_count", {5'd0, fifo_count}, 8'd4);
        chk("ovf_reject", 8'(rej_cnt), 8'd1);
        chk("ovf_credit", credit_total, 8'd4);
        chk("ovf_stall", 8'(seen.size()), 8'd0);
        accept_en = 1'b1;
        w = 0;
        while (money == 3'b000 && w < 20) begin
            tick();
            w++;
        end
        chk("drain_start", {5'd0, money}, 8'd1);
        for (int k = 1; k < 7; k++) begin
            tick();
            chk("drain_seq", {5'd0, money}, (k % 2 == 1) ? 8'd0 : 8'd1);
        end
        ticks(3);
        chk("drain_total", 8'(seen.size()), 8'd4);
        chk("drain_count", {5'd0, fifo_count}, 8'd0);

        // Ordered quarter, half, dollar
        do_reset();
        insert(3'b001);
        insert(3'b010);
        insert(3'b100);
        ticks(10);
        chk("ord_n", 8'(seen.size()), 8'd3);
        if (seen.size() == 3) begin
            chk("ord_0", {5'd0, seen[0]}, 8'd1);
            chk("ord_1", {5'd0, seen[1]}, 8'd2);
            chk("ord_2", {5'd0, seen[2]}, 8'd3);
        end
        chk("ord_credit", credit_total, 8'd7);

        // Reset with three codes buffered discards them
        do_reset();
        accept_en = 1'b0;
        for (int i = 0; i < 3; i++) insert(3'b001);
        ticks(2);
        chk("mid_count", {5'd0, fifo_count}, 8'd3);
        rst = 1'b1;
        tick();
        chk("mid_money", {5'd0, money}, 8'd0);
        chk("mid_reject", {7'd0, coin_reject}, 8'd0);
        chk("mid_count0", {5'd0, fifo_count}, 8'd0);
        chk("mid_credit", credit_total, 8'd0);
        rst = 1'b0;
        accept_en = 1'b1;
        seen.delete();
        ticks(20);
        chk("mid_none", 8'(seen.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
